// File: rtl/spu_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spu_wb_pkg
// Description : Shared types and constants for the SPU writeback slice.
//               Result packets are big-endian: bit 0 is the MSB of the data.
// Revision    : 1.0 - initial release
// ============================================================================
package spu_wb_pkg;

    localparam int PKT_W  = 139;
    localparam int DATA_W = 128;
    localparam int ADDR_W = 7;
    localparam int UNIT_W = 3;
    localparam int WR_BIT = 131;
    localparam int RT_LSB = 132;

    // Field order mirrors the wire format: data[0:127], unit[128:130],
    // wr[131], rt[132:138]. First struct member lands on packet bit 0.
    typedef struct packed {
        logic [0:DATA_W-1] data;
        logic [0:UNIT_W-1] unit_id;
        logic              wr;
        logic [0:ADDR_W-1] rt;
    } pkt_t;

endpackage : spu_wb_pkg
`default_nettype wire

// File: rtl/spu_wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : spu_wb_queue
// Description : DEPTH-entry in-order circular queue, two enqueue ports
//               (even older than odd) and one dequeue per cycle. Exposes all
//               entries in age order (entry 0 = head) for read bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module spu_wb_queue
    import spu_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [0:PKT_W-1]         even_in,
    input  logic [0:PKT_W-1]         odd_in,
    output logic [0:PKT_W-1]         head_pkt,
    output logic                     head_valid,
    output logic [2:0]               count,
    output logic                     overflow,
    output logic [DEPTH*PKT_W-1:0]   entries,
    output logic [DEPTH-1:0]         entry_valid
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    pkt_t          r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [2:0]    r_count;
    logic          r_overflow;

    pkt_t          w_even;
    pkt_t          w_odd;
    logic          w_deq;
    logic [3:0]    w_free;
    logic          w_even_acc;
    logic          w_odd_acc;
    logic          w_drop;
    logic [PW-1:0] w_odd_slot;

    assign w_even = pkt_t'(even_in);
    assign w_odd  = pkt_t'(odd_in);

    // Free slots include the head leaving this cycle; odd loses when short.
    always_comb begin
        w_deq      = (r_count != 3'd0);
        w_free     = 4'(DEPTH) - {1'b0, r_count} + {3'b000, w_deq};
        w_even_acc = w_even.wr && (w_free != 4'd0);
        w_odd_acc  = w_odd.wr && (w_free > {3'b000, w_even_acc});
        w_drop     = (w_even.wr && !w_even_acc) || (w_odd.wr && !w_odd_acc);
        w_odd_slot = r_tail + PW'(w_even_acc);
    end

    // Pointer, occupancy and sticky-overflow state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= 3'd0;
            r_overflow <= 1'b0;
        end else begin
            r_head  <= r_head + PW'(w_deq);
            r_tail  <= r_tail + PW'(w_even_acc) + PW'(w_odd_acc);
            r_count <= r_count + 3'(w_even_acc) + 3'(w_odd_acc) - 3'(w_deq);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Payload storage; contents are only meaningful under entry_valid.
    always_ff @(posedge clk) begin
        if (w_even_acc) begin
            r_mem[r_tail] <= w_even;
        end
        if (w_odd_acc) begin
            r_mem[w_odd_slot] <= w_odd;
        end
    end

    // Present entries oldest-first so consumers can scan by age.
    always_comb begin
        entries     = '0;
        entry_valid = '0;
        for (int k = 0; k < DEPTH; k++) begin
            entries[k*PKT_W +: PKT_W] = r_mem[r_head + PW'(k)];
            entry_valid[k]            = (k < int'(r_count));
        end
    end

    assign head_pkt   = r_mem[r_head];
    assign head_valid = (r_count != 3'd0);
    assign count      = r_count;
    assign overflow   = r_overflow;

endmodule : spu_wb_queue
`default_nettype wire

// File: rtl/spu_writeback.sv
`default_nettype none
// ============================================================================
// Module      : spu_writeback
// Description : Writeback stage. Queues even/odd pipe results in order and
//               drains one per cycle into a 128 x 128-bit register file with
//               three combinational read ports (ra/rb/rc).
//               Build option WB_BYPASS_EN: reads also see pipe inputs and
//               queued, unwritten results (youngest wins). Without it, reads
//               come from the register file only.
// Revision    : 1.0 - initial release
// ============================================================================
module spu_writeback
    import spu_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int NREG  = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [0:PKT_W-1]  pipe_even_in,
    input  logic [0:PKT_W-1]  pipe_odd_in,
    input  logic [6:0]        addr_ra,
    input  logic [6:0]        addr_rb,
    input  logic [6:0]        addr_rc,
    output logic [0:DATA_W-1] ra,
    output logic [0:DATA_W-1] rb,
    output logic [0:DATA_W-1] rc,
    output logic              stall,
    output logic              overflow,
    output logic [2:0]        q_count
);

    logic [0:DATA_W-1]      r_rf [NREG];

    logic [0:PKT_W-1]       w_head_raw;
    pkt_t                   w_head;
    logic                   w_head_valid;
    logic [2:0]             w_count;
    logic [DEPTH*PKT_W-1:0] w_q_flat;
    logic [DEPTH-1:0]       w_q_valid;
    logic                   w_unused;

    spu_wb_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk         (clk),
        .reset       (reset),
        .even_in     (pipe_even_in),
        .odd_in      (pipe_odd_in),
        .head_pkt    (w_head_raw),
        .head_valid  (w_head_valid),
        .count       (w_count),
        .overflow    (overflow),
        .entries     (w_q_flat),
        .entry_valid (w_q_valid)
    );

    assign w_head  = pkt_t'(w_head_raw);
    assign q_count = w_count;
    assign stall   = (DEPTH - int'(w_count)) < 2;

    // Unit id is carried but not consumed; fold spare bits into one sink.
    assign w_unused = ^{pipe_even_in, pipe_odd_in, w_q_flat, w_q_valid};

    // Register file: cleared on reset, written from the queue head.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
        end else if (w_head_valid) begin
            r_rf[w_head.rt] <= w_head.data;
        end
    end

`ifdef WB_BYPASS_EN
    pkt_t w_even;
    pkt_t w_odd;
    assign w_even = pkt_t'(pipe_even_in);
    assign w_odd  = pkt_t'(pipe_odd_in);
`endif

    // Oldest source applied first so each younger match overrides it.
    function automatic logic [0:DATA_W-1] read_port(input logic [ADDR_W-1:0] addr);
`ifdef WB_BYPASS_EN
        pkt_t e;
`endif
        read_port = r_rf[addr];
`ifdef WB_BYPASS_EN
        for (int k = 0; k < DEPTH; k++) begin
            e = pkt_t'(w_q_flat[k*PKT_W +: PKT_W]);
            if (w_q_valid[k] && (e.rt == addr)) begin
                read_port = e.data;
            end
        end
        if (w_even.wr && (w_even.rt == addr)) begin
            read_port = w_even.data;
        end
        if (w_odd.wr && (w_odd.rt == addr)) begin
            read_port = w_odd.data;
        end
`endif
    endfunction

    // Three independent operand read ports.
    always_comb ra = read_port(addr_ra);
    always_comb rb = read_port(addr_rb);
    always_comb rc = read_port(addr_rc);

endmodule : spu_writeback
`default_nettype wire

// File: tb/tb_spu_writeback.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_spu_writeback
// Description : Directed self-checking bench for spu_writeback. Expected
//               read values depend on whether WB_BYPASS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spu_writeback;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [0:138] pipe_even_in = '0;
    logic [0:138] pipe_odd_in = '0;
    logic [6:0]   addr_ra = '0;
    logic [6:0]   addr_rb = '0;
    logic [6:0]   addr_rc = '0;
    logic [0:127] ra, rb, rc;
    logic         stall, overflow;
    logic [2:0]   q_count;

    int n_pass  = 0;
    int n_total = 0;

    localparam logic [127:0] D2   = 128'h0000_0001_0000_0000_0000_0000_0000_0002;
    localparam logic [127:0] DA   = {8{16'hAAAA}};
    localparam logic [127:0] D5   = {8{16'h5555}};
    localparam logic [127:0] D7   = {8{16'h1234}};
    localparam logic [127:0] ZERO = '0;

    spu_writeback #(.DEPTH(4), .NREG(128)) dut (
        .clk          (clk),
        .reset        (reset),
        .pipe_even_in (pipe_even_in),
        .pipe_odd_in  (pipe_odd_in),
        .addr_ra      (addr_ra),
        .addr_rb      (addr_rb),
        .addr_rc      (addr_rc),
        .ra           (ra),
        .rb           (rb),
        .rc           (rc),
        .stall        (stall),
        .overflow     (overflow),
        .q_count      (q_count)
    );

    always #5 clk = ~clk;

    function automatic logic [0:138] mkpkt(input logic wr, input logic [6:0] rt,
                                           input logic [127:0] data);
        mkpkt = {data, 3'b101, wr, rt};
    endfunction

    function automatic logic [127:0] dat(input logic [6:0] rt);
        dat = {32'hC0DE_0000, 89'd0, rt};
    endfunction

    // Advance one edge; outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pipe_even_in = '0;
        pipe_odd_in  = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        step();
        step();
        reset = 1'b0;
        addr_ra = 7'd0; addr_rb = 7'd5; addr_rc = 7'd127;
        #1;
        n_total++; if (ra !== ZERO) $display("FAIL reset_ra got=%h exp=%h", ra, ZERO); else n_pass++;
        n_total++; if (rb !== ZERO) $display("FAIL reset_rb got=%h exp=%h", rb, ZERO); else n_pass++;
        n_total++; if (rc !== ZERO) $display("FAIL reset_rc got=%h exp=%h", rc, ZERO); else n_pass++;
        n_total++; if (q_count !== 3'd0) $display("FAIL reset_qcount got=%0d exp=0", q_count); else n_pass++;
        n_total++; if (stall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", stall); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got=%b exp=0", overflow); else n_pass++;
    endtask

    task automatic test_single();
        logic [127:0] e;
        addr_ra = 7'd3;
        pipe_even_in = mkpkt(1'b1, 7'd3, D2);
        #1;
        e = BYP ? D2 : ZERO;
        n_total++; if (ra !== e) $display("FAIL single_same_cycle got=%h exp=%h", ra, e); else n_pass++;
        step();
        idle_inputs();
        #1;
        n_total++; if (q_count !== 3'd1) $display("FAIL single_qcount_n got=%0d exp=1", q_count); else n_pass++;
        n_total++; if (ra !== e) $display("FAIL single_queued_read got=%h exp=%h", ra, e); else n_pass++;
        step();
        n_total++; if (ra !== D2) $display("FAIL single_rf got=%h exp=%h", ra, D2); else n_pass++;
        n_total++; if (q_count !== 3'd0) $display("FAIL single_qcount_n1 got=%0d exp=0", q_count); else n_pass++;
    endtask

    task automatic test_same_rt();
        addr_ra = 7'd10;
        pipe_even_in = mkpkt(1'b1, 7'd10, DA);
        pipe_odd_in  = mkpkt(1'b1, 7'd10, D5);
        #1;
        n_total++; if (ra !== (BYP ? D5 : ZERO)) $display("FAIL samert_pre got=%h exp=%h", ra, BYP ? D5 : ZERO); else n_pass++;
        step();
        idle_inputs();
        #1;
        n_total++; if (q_count !== 3'd2) $display("FAIL samert_q2 got=%0d exp=2", q_count); else n_pass++;
        n_total++; if (ra !== (BYP ? D5 : ZERO)) $display("FAIL samert_e1 got=%h exp=%h", ra, BYP ? D5 : ZERO); else n_pass++;
        step();
        n_total++; if (q_count !== 3'd1) $display("FAIL samert_q1 got=%0d exp=1", q_count); else n_pass++;
        n_total++; if (ra !== (BYP ? D5 : DA)) $display("FAIL samert_e2 got=%h exp=%h", ra, BYP ? D5 : DA); else n_pass++;
        step();
        n_total++; if (q_count !== 3'd0) $display("FAIL samert_q0 got=%0d exp=0", q_count); else n_pass++;
        n_total++; if (ra !== D5) $display("FAIL samert_final got=%h exp=%h", ra, D5); else n_pass++;
    endtask

    // Four dual-issue cycles; free slots per cycle are 4,3,2,1 so only the
    // last odd packet (rt 27) is dropped.
    task automatic test_overflow();
        logic [2:0] exp_q [4] = '{3'd2, 3'd3, 3'd4, 3'd4};
        logic       exp_s [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic       exp_o [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int c = 0; c < 4; c++) begin
            pipe_even_in = mkpkt(1'b1, 7'(20 + 2*c), dat(7'(20 + 2*c)));
            pipe_odd_in  = mkpkt(1'b1, 7'(21 + 2*c), dat(7'(21 + 2*c)));
            step();
            n_total++; if (q_count !== exp_q[c]) $display("FAIL ovf_qcount_c%0d got=%0d exp=%0d", c, q_count, exp_q[c]); else n_pass++;
            n_total++; if (stall !== exp_s[c]) $display("FAIL ovf_stall_c%0d got=%b exp=%b", c, stall, exp_s[c]); else n_pass++;
            n_total++; if (overflow !== exp_o[c]) $display("FAIL ovf_flag_c%0d got=%b exp=%b", c, overflow, exp_o[c]); else n_pass++;
        end
        idle_inputs();
        for (int c = 0; c < 4; c++) step();
        addr_ra = 7'd20; addr_rb = 7'd26; addr_rc = 7'd27;
        #1;
        n_total++; if (q_count !== 3'd0) $display("FAIL ovf_drained got=%0d exp=0", q_count); else n_pass++;
        n_total++; if (ra !== dat(7'd20)) $display("FAIL ovf_rt20 got=%h exp=%h", ra, dat(7'd20)); else n_pass++;
        n_total++; if (rb !== dat(7'd26)) $display("FAIL ovf_rt26 got=%h exp=%h", rb, dat(7'd26)); else n_pass++;
        n_total++; if (rc !== ZERO) $display("FAIL ovf_rt27_dropped got=%h exp=%h", rc, ZERO); else n_pass++;
        n_total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", overflow); else n_pass++;
    endtask

    task automatic test_reset_midflight();
        pipe_even_in = mkpkt(1'b1, 7'd40, dat(7'd40));
        pipe_odd_in  = mkpkt(1'b1, 7'd41, dat(7'd41));
        step();
        pipe_even_in = mkpkt(1'b1, 7'd42, dat(7'd42));
        pipe_odd_in  = mkpkt(1'b1, 7'd43, dat(7'd43));
        step();
        n_total++; if (q_count !== 3'd3) $display("FAIL rstmid_fill got=%0d exp=3", q_count); else n_pass++;
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        addr_ra = 7'd3; addr_rb = 7'd40; addr_rc = 7'd10;
        #1;
        n_total++; if (q_count !== 3'd0) $display("FAIL rstmid_qcount got=%0d exp=0", q_count); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL rstmid_overflow got=%b exp=0", overflow); else n_pass++;
        n_total++; if (ra !== ZERO) $display("FAIL rstmid_rf3 got=%h exp=%h", ra, ZERO); else n_pass++;
        n_total++; if (rb !== ZERO) $display("FAIL rstmid_rf40 got=%h exp=%h", rb, ZERO); else n_pass++;
        n_total++; if (rc !== ZERO) $display("FAIL rstmid_rf10 got=%h exp=%h", rc, ZERO); else n_pass++;
        for (int c = 0; c < 4; c++) step();
        addr_ra = 7'd41; addr_rb = 7'd42; addr_rc = 7'd43;
        #1;
        n_total++; if (ra !== ZERO) $display("FAIL rstmid_rt41 got=%h exp=%h", ra, ZERO); else n_pass++;
        n_total++; if (rb !== ZERO) $display("FAIL rstmid_rt42 got=%h exp=%h", rb, ZERO); else n_pass++;
        n_total++; if (rc !== ZERO) $display("FAIL rstmid_rt43 got=%h exp=%h", rc, ZERO); else n_pass++;
    endtask

    task automatic test_odd_only_rb();
        logic [127:0] e;
        addr_rb = 7'd7; addr_rc = 7'd8;
        pipe_odd_in = mkpkt(1'b1, 7'd7, D7);
        #1;
        e = BYP ? D7 : ZERO;
        n_total++; if (rb !== e) $display("FAIL odd_pre got=%h exp=%h", rb, e); else n_pass++;
        step();
        idle_inputs();
        #1;
        n_total++; if (rb !== e) $display("FAIL odd_queued got=%h exp=%h", rb, e); else n_pass++;
        n_total++; if (rc !== ZERO) $display("FAIL odd_other_addr got=%h exp=%h", rc, ZERO); else n_pass++;
        step();
        n_total++; if (rb !== D7) $display("FAIL odd_written got=%h exp=%h", rb, D7); else n_pass++;
        n_total++; if (q_count !== 3'd0) $display("FAIL odd_qcount got=%0d exp=0", q_count); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_same_rt();
        test_overflow();
        test_reset_midflight();
        test_odd_only_rb();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_spu_writeback
`default_nettype wire
